// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Combinational only: no latency, no backpressure.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int   UART_PRESCALE_DEF = 16;
   localparam int   UART_DATA_BITS    = 8;
   localparam logic UART_PAR_EVEN     = 1'b0;
   localparam logic UART_PAR_ODD      = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// LSB-first receive shift register: new bit enters the MSB and moves toward bit 0.
// Updates one cycle after enable; no backpressure, holds while enable is low.
module rx_shift_reg
   import uart_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      data_in,
   input  logic                      enable,
   output logic [UART_DATA_BITS-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out <= '0;
      end else if (enable) begin
         data_out <= {data_in, data_out[UART_DATA_BITS-1:1]};
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, 3-sample majority per bit, parity/stop check.
// Frame-end flags register one cycle after the stop-bit decision; no backpressure.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int PRESCALE   = UART_PRESCALE_DEF,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = UART_PAR_EVEN
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      data_valid,
   output logic                      par_err,
   output logic                      stop_err,
   output logic                      busy
);

   localparam int CW = $clog2(PRESCALE);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] MID_LO   = CW'(PRESCALE / 2 - 1);
   localparam logic [CW-1:0] MID      = CW'(PRESCALE / 2);
   localparam logic [CW-1:0] MID_HI   = CW'(PRESCALE / 2 + 1);
   localparam logic [CW-1:0] LAST     = CW'(PRESCALE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

   rx_state_t     state;
   logic          sync_q1;
   logic          rx_s;
   logic [CW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          samp_a;
   logic          samp_b;
   logic          parity;
   logic          par_mis;
   logic          decide;
   logic          bit_dec;
   logic          shift_en;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q1 <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync_q1 <= rx_in;
         rx_s    <= sync_q1;
      end
   end

   // Third vote is the live synchronized line in the decision cycle itself.
   assign decide   = (state != IDLE) && (edge_cnt == MID_HI);
   assign bit_dec  = maj3(samp_a, samp_b, rx_s);
   assign shift_en = (state == DATA) && decide;

   always_ff @(posedge clk) begin
      if (!rst) begin
         samp_a <= 1'b0;
         samp_b <= 1'b0;
      end else if (state != IDLE) begin
         if (edge_cnt == MID_LO) samp_a <= rx_s;
         if (edge_cnt == MID)    samp_b <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         parity     <= 1'b0;
         par_mis    <= 1'b0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stop_err   <= 1'b0;
         edge_cnt   <= (edge_cnt == LAST) ? '0 : edge_cnt + 1'b1;
         case (state)
            IDLE: begin
               edge_cnt <= '0;
               if (!rx_s) begin
                  state   <= START;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  parity  <= 1'b0;
                  par_mis <= 1'b0;
               end
            end
            START: begin
               if (decide && bit_dec) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (edge_cnt == LAST) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (decide) parity <= parity ^ bit_dec;
               if (edge_cnt == LAST) begin
                  if (bit_cnt == LAST_BIT) state <= PARITY_EN ? PARITY : STOP;
                  else                     bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (decide) par_mis <= (bit_dec != (parity ^ PARITY_ODD));
               if (edge_cnt == LAST) state <= STOP;
            end
            STOP: begin
               // Leave mid stop bit so an immediately following start edge is caught.
               if (decide) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  stop_err   <= !bit_dec;
                  par_err    <= par_mis;
                  data_valid <= bit_dec && !par_mis;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   rx_shift_reg u_shift (
      .clk      (clk),
      .rst      (rst),
      .data_in  (bit_dec),
      .enable   (shift_en),
      .data_out (data_out)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench: even- and odd-parity receivers share one line; expected frame results come from a frame-level model.
module tb_uart_rx_ctrl;

   localparam int P = 8;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [7:0] dout0, dout1;
   logic       dv0, pe0, se0, busy0;
   logic       dv1, pe1, se1, busy1;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_end0 = 0;
   int prev_end0 = 0;

   // {data, data_valid, par_err, stop_err} expected at each frame end
   logic [10:0] expq0[$];
   logic [10:0] expq1[$];

   uart_rx_ctrl #(.PRESCALE(P), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
      .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(dout0),
      .data_valid(dv0), .par_err(pe0), .stop_err(se0), .busy(busy0));

   uart_rx_ctrl #(.PRESCALE(P), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
      .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(dout1),
      .data_valid(dv1), .par_err(pe1), .stop_err(se1), .busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] model(input logic [7:0] d, input logic pbit,
                                         input logic sbit, input logic odd);
      logic perr;
      logic serr;
      perr = (pbit != ((^d) ^ odd));
      serr = !sbit;
      return {d, !perr && !serr, perr, serr};
   endfunction

   task automatic line(input logic b, input int n);
      rx_in = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int gap);
      expq0.push_back(model(d, pbit, sbit, 1'b0));
      expq1.push_back(model(d, pbit, sbit, 1'b1));
      line(1'b0, P);
      for (int i = 0; i < 8; i++) line(d[i], P);
      line(pbit, P);
      line(sbit, P);
      line(1'b1, gap * P);
   endtask

   always @(negedge clk) begin
      logic [10:0] e;
      if (rst && (dv0 || pe0 || se0)) begin
         prev_end0 = last_end0;
         last_end0 = cyc;
         if (expq0.size() == 0) begin
            chk("unexpected_pulse_even", 1, 0);
         end else begin
            e = expq0.pop_front();
            chk("data_even", dout0, e[10:3]);
            chk("flags_even", {dv0, pe0, se0}, e[2:0]);
            chk("busy_at_end_even", busy0, 0);
         end
      end
      if (rst && (dv1 || pe1 || se1)) begin
         if (expq1.size() == 0) begin
            chk("unexpected_pulse_odd", 1, 0);
         end else begin
            e = expq1.pop_front();
            chk("data_odd", dout1, e[10:3]);
            chk("flags_odd", {dv1, pe1, se1}, e[2:0]);
            chk("busy_at_end_odd", busy1, 0);
         end
      end
   end

   initial begin
      logic [7:0] d;
      logic [7:0] keep;
      logic       pbit;
      logic       sbit;
      int         gap;
      int         busy_cnt;

      rst   = 1'b0;
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_even", dout0, 8'h00);
      chk("rst_flags_even", {dv0, pe0, se0, busy0}, 4'b0000);
      chk("rst_data_odd", dout1, 8'h00);
      chk("rst_flags_odd", {dv1, pe1, se1, busy1}, 4'b0000);
      rst = 1'b1;
      line(1'b1, 2 * P);

      // 0xA5 has four ones: even parity bit 0, odd parity bit 1
      send_frame(8'hA5, 1'b0, 1'b1, 1);
      send_frame(8'hA5, 1'b1, 1'b1, 1);
      send_frame(8'h3C, 1'b0, 1'b0, 2);
      send_frame(8'h81, 1'b0, 1'b1, 1);

      // short low glitch on an idle line
      keep = dout0;
      line(1'b0, 2);
      rx_in = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy0) busy_cnt++;
         @(posedge clk);
         #1;
      end
      chk("glitch_busy_seen", busy_cnt > 0, 1);
      chk("glitch_busy_len_ok", busy_cnt <= P / 2 + 2, 1);
      chk("glitch_data_kept", dout0, keep);
      chk("glitch_idle_after", busy0, 0);

      // back-to-back, no idle between frames
      send_frame(8'h00, 1'b0, 1'b1, 0);
      send_frame(8'hFF, 1'b0, 1'b1, 1);
      chk("b2b_spacing", last_end0 - prev_end0, 11 * P);

      // reset part-way through data bit 4 of 0x5A
      d = 8'h5A;
      line(1'b0, P);
      for (int i = 0; i < 4; i++) line(d[i], P);
      line(d[4], P / 2);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_data_even", dout0, 8'h00);
      chk("midrst_flags_even", {dv0, pe0, se0, busy0}, 4'b0000);
      chk("midrst_data_odd", dout1, 8'h00);
      chk("midrst_flags_odd", {dv1, pe1, se1, busy1}, 4'b0000);
      rx_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      line(1'b1, 3 * P);
      send_frame(8'hC3, 1'b0, 1'b1, 1);

      // random frames with occasional parity and stop faults
      for (int n = 0; n < 40; n++) begin
         d    = 8'($urandom);
         pbit = (^d) ^ ($urandom_range(0, 3) == 0);
         sbit = ($urandom_range(0, 4) != 0);
         gap  = sbit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         send_frame(d, pbit, sbit, gap);
      end

      line(1'b1, 3 * P);
      chk("drain_even", expq0.size(), 0);
      chk("drain_odd", expq1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the 8-bit LSB-first shift-register data path of the receiver. It oversamples the serial line and detects start bits. It issues one shift-enable per data bit, checks optional parity and the stop bit, and flags a completed byte. It sits between the raw `rx_in` pin and the receive buffer / register interface.

## Interface
- `PRESCALE`, 16: clk cycles per bit; even, ≥ 6.
- `PARITY_EN`, 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `rx_in` in 1: serial line, idle high, asynchronous to `clk`.
- `data_out` out 8: received byte; LSB is the first data bit.
- `data_valid` out 1: one-cycle pulse; frame good and `data_out` final.
- `par_err` out 1: one-cycle pulse; parity mismatch.
- `stop_err` out 1: one-cycle pulse; stop bit sampled 0.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer; both flops reset to 1. `rx_s` is the synchronizer output.
- Counters:
  - `edge_cnt` counts 0..PRESCALE-1 and wraps to 0.
  - `bit_cnt` counts 0..7.
  - Both clear on entry to START.
- Bit decision:
  - `rx_s` is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1, where P = PRESCALE.
  - The decided bit is the majority of the three samples, valid in the cycle `edge_cnt` = P/2+1 ("decision cycle").
- FSM states, encoded as an enum: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `rx_s` = 0.
  - START, decision = 1 → IDLE (glitch). No shift and no flags.
  - START, decision = 0 → stays in START until `edge_cnt` = P-1, then → DATA.
  - DATA:
    - In the decision cycle, assert shift-enable for exactly one cycle with the decided bit as serial input.
    - Fold the decided bit into the running parity.
    - At `edge_cnt` = P-1: if `bit_cnt` = 7, go to PARITY (`PARITY_EN` = 1) or STOP; otherwise increment `bit_cnt`.
  - PARITY:
    - In the decision cycle, compare the decided bit with the expected parity and latch the mismatch.
    - At P-1 → STOP.
  - STOP:
    - In the decision cycle, → IDLE and emit the frame-end outputs.
    - Returning mid-stop-bit allows back-to-back frames.
- Frame-end outputs, all in the same cycle:
  - `stop_err` = !decision.
  - `par_err` = latched mismatch.
  - `data_valid` = !stop_err && !par_err.
- Shift path:
  - Right shift, new bit enters bit 7: `{bit, q[7:1]}`.
  - After 8 shifts, bit 0 of `data_out` holds the first received bit.
  - `data_out` holds its value until the next frame's first shift.
- Reset values:
  - `data_out` = 0x00.
  - `data_valid`, `par_err`, `stop_err`, `busy` = 0.
  - FSM = IDLE.
  - Counters and parity = 0.
- Reset mid-frame aborts the frame:
  - All outputs return to their reset values on the next edge.
  - No flag pulses.
  - The frame's remaining bits are ignored until a new falling edge is seen in IDLE.
- A low level on `rx_s` in IDLE always starts a frame. A line held low (break) therefore yields `stop_err` repeatedly.

## Timing
- `rx_in` falls at edge k → `rx_s` low at k+2 → `busy` high at k+3.
- Shift-enable pulses: 8 per frame, spaced exactly PRESCALE cycles apart.
- Frame-end pulse time, measured from the START entry cycle:
  - (9 + `PARITY_EN`)·P + P/2 + 1 cycles.
  - `busy` falls in the same cycle.
- `data_out` is updated one cycle after each shift-enable. It is final at least PRESCALE cycles before `data_valid`.
- All outputs are registered. There are no combinational paths from `rx_in`.

## Structure
- Package `uart_pkg` contains:
  - The FSM state enum `rx_state_t`.
  - The default PRESCALE.
  - The frame length constant `UART_DATA_BITS` = 8.
  - The parity encodings.
- Sub-module `rx_shift_reg` holds the 8-bit shift register.
  - Ports: `clk`, `rst` (same reset style as this block), `data_in`, `enable`, `data_out`.
  - Instantiated once.
- The FSM, counters, synchronizer and parity logic live in `uart_rx_ctrl`.

## Test plan
All cases use PRESCALE = 8 unless stated.
- Even parity, frame 0xA5 with parity bit 0 and stop bit 1 → one `data_valid` with `data_out` = 0xA5, no error pulses.
- Same frame with parity bit 1 → `par_err` pulse and no `data_valid`. With `PARITY_ODD` = 1, parity bit 1 → `data_valid` with 0xA5.
- Frame 0x3C with stop bit 0 → `stop_err` pulse and no `data_valid`. The next frame 0x81 is received correctly.
- `rx_in` low for 2 cycles in IDLE (glitch) → `busy` high, then back to IDLE within P/2+2 cycles. No shift, `data_out` unchanged, no pulses.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `data_valid` pulses with the correct bytes, spacing = (10 + `PARITY_EN`)·8 cycles.
- `rst` asserted during data bit 4 of 0x5A → all outputs are at reset values after the edge. A subsequent full frame 0xC3 → `data_valid` with 0xC3.
